// File: rtl/verlet_pkg.sv
// Shared definitions for the Verlet integration core.
// Holds the sequencer state encoding and the default node count, base address and address stride
// that the node update units also use.
package verlet_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StSync,
        StDrain,
        StDone
    } state_e;

    localparam int unsigned DefNodesPerCore = 5;
    localparam int unsigned DefAddrBase     = 1;
    localparam int unsigned DefAddrStride   = 5;

endpackage

// File: rtl/verlet_wb_delay.sv
// Write-back delay line for the Verlet sequencer.
// Holds a DEPTH-deep shift register of {en, addr} with synchronous active-high reset, so the
// output reproduces the input exactly DEPTH cycles later.
// Used only when VERLET_SEQ_WRITEBACK_EN is defined.
// Ports:
//   clk, reset        clock, synchronous active-high reset (flushes every stage)
//   in_en, in_addr    read strobe/address entering the line
//   out_en, out_addr  the same strobe/address after DEPTH cycles
module verlet_wb_delay
    import verlet_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_en,
    input  logic [WIDTH-1:0] in_addr,
    output logic             out_en,
    output logic [WIDTH-1:0] out_addr
);

    logic [DEPTH-1:0] en_q;
    logic [WIDTH-1:0] addr_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            en_q[0]   <= in_en;
            addr_q[0] <= in_addr;
            for (int i = 1; i < DEPTH; i++) begin
                en_q[i]   <= en_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    assign out_en   = en_q[DEPTH-1];
    assign out_addr = addr_q[DEPTH-1];

endmodule

// File: rtl/verlet_core_sequencer.sv
// Sequencer for one Verlet integration core.
// A start request runs num_steps Verlet steps. Each step is a sweep over NODES_PER_CORE nodes,
// giving a one-hot node strobe and a strided node-RAM read address per node. A one-cycle SYNC
// barrier follows each sweep, and the run ends with a one-cycle done pulse. stall freezes the sweep.
// Optional feature macro: VERLET_SEQ_WRITEBACK_EN. When it is defined, the block adds a write-back
// address stream that is the read stream delayed WB_LATENCY cycles, plus a DRAIN state before DONE.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   start        run request, sampled only in IDLE
//   num_steps    steps to run, captured with start
//   stall        holds the current node while in FETCH
//   busy         high in FETCH, SYNC and DRAIN
//   done         one-cycle end-of-run pulse
//   node_sel     one-hot current node, 0 when not fetching
//   ram_rd_en    node RAM read strobe
//   ram_rd_addr  node RAM read address
//   step_cnt     steps completed in the current run
//   ram_wr_en    write-back strobe (0 without the macro)
//   ram_wr_addr  write-back address (0 without the macro)
module verlet_core_sequencer
    import verlet_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned NODES_PER_CORE = DefNodesPerCore,
    parameter int unsigned ADDR_BASE      = DefAddrBase,
    parameter int unsigned ADDR_STRIDE    = DefAddrStride,
    parameter int unsigned STEP_W         = 16,
    parameter int unsigned WB_LATENCY     = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [STEP_W-1:0]         num_steps,
    input  logic                      stall,
    output logic                      busy,
    output logic                      done,
    output logic [NODES_PER_CORE-1:0] node_sel,
    output logic                      ram_rd_en,
    output logic [WIDTH-1:0]          ram_rd_addr,
    output logic [STEP_W-1:0]         step_cnt,
    output logic                      ram_wr_en,
    output logic [WIDTH-1:0]          ram_wr_addr
);

    state_e                    state_q;
    logic [NODES_PER_CORE-1:0] node_sel_q;
    logic [WIDTH-1:0]          rd_addr_q;
    logic                      rd_active_q;
    logic                      busy_q;
    logic                      done_q;
    logic [STEP_W-1:0]         step_cnt_q;
    logic [STEP_W-1:0]         num_steps_q;
    logic [STEP_W-1:0]         step_next;

`ifdef VERLET_SEQ_WRITEBACK_EN
    localparam int unsigned DrainW = (WB_LATENCY > 1) ? $clog2(WB_LATENCY) : 1;
    logic [DrainW-1:0] drain_cnt_q;
`endif

    assign step_next = step_cnt_q + STEP_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            node_sel_q  <= '0;
            rd_addr_q   <= '0;
            rd_active_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            step_cnt_q  <= '0;
            num_steps_q <= '0;
`ifdef VERLET_SEQ_WRITEBACK_EN
            drain_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        step_cnt_q <= '0;
                        if (num_steps == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            num_steps_q <= num_steps;
                            state_q     <= StFetch;
                            busy_q      <= 1'b1;
                            node_sel_q  <= NODES_PER_CORE'(1);
                            rd_addr_q   <= WIDTH'(ADDR_BASE);
                            rd_active_q <= 1'b1;
                        end
                    end
                end
                StFetch: begin
                    if (!stall) begin
                        if (node_sel_q[NODES_PER_CORE-1]) begin
                            state_q     <= StSync;
                            node_sel_q  <= '0;
                            rd_addr_q   <= '0;
                            rd_active_q <= 1'b0;
                        end else begin
                            // Repeated addition; wraps modulo 2^WIDTH.
                            node_sel_q <= node_sel_q << 1;
                            rd_addr_q  <= rd_addr_q + WIDTH'(ADDR_STRIDE);
                        end
                    end
                end
                StSync: begin
                    step_cnt_q <= step_next;
                    if (step_next == num_steps_q) begin
`ifdef VERLET_SEQ_WRITEBACK_EN
                        state_q     <= StDrain;
                        drain_cnt_q <= '0;
`else
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`endif
                    end else begin
                        state_q     <= StFetch;
                        node_sel_q  <= NODES_PER_CORE'(1);
                        rd_addr_q   <= WIDTH'(ADDR_BASE);
                        rd_active_q <= 1'b1;
                    end
                end
`ifdef VERLET_SEQ_WRITEBACK_EN
                StDrain: begin
                    // The last read enters the delay line one cycle before SYNC, so WB_LATENCY
                    // drain cycles leave it empty by the time done is raised.
                    if (drain_cnt_q == DrainW'(WB_LATENCY - 1)) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + DrainW'(1);
                    end
                end
`endif
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign node_sel    = node_sel_q;
    assign ram_rd_addr = rd_addr_q;
    assign step_cnt    = step_cnt_q;
    // The strobe drops in the same cycle stall is raised, while the registered address holds.
    assign ram_rd_en   = rd_active_q & ~stall;

`ifdef VERLET_SEQ_WRITEBACK_EN
    verlet_wb_delay #(
        .WIDTH (WIDTH),
        .DEPTH (WB_LATENCY)
    ) u_wb_delay (
        .clk      (clk),
        .reset    (reset),
        .in_en    (ram_rd_en),
        .in_addr  (rd_addr_q),
        .out_en   (ram_wr_en),
        .out_addr (ram_wr_addr)
    );
`else
    assign ram_wr_en   = 1'b0;
    assign ram_wr_addr = '0;
`endif

endmodule

// File: tb/tb_verlet_core_sequencer.sv
// Self-checking bench for verlet_core_sequencer.
// It drives per-cycle input plans (a set of directed runs followed by random traffic) and builds
// an expected schedule for every cycle from the run rules. A negedge compare process checks the
// DUT outputs against that schedule and against a few hand-computed literals.
module tb_verlet_core_sequencer;

    localparam int N      = 5;
    localparam int BASE   = 1;
    localparam int STRIDE = 5;
    localparam int LAT    = 3;
    localparam int TOTAL  = 2500;
`ifdef VERLET_SEQ_WRITEBACK_EN
    localparam int LX = LAT;
`else
    localparam int LX = 0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] num_steps;
    logic        stall;
    logic        busy;
    logic        done;
    logic [N-1:0] node_sel;
    logic        ram_rd_en;
    logic [31:0] ram_rd_addr;
    logic [15:0] step_cnt;
    logic        ram_wr_en;
    logic [31:0] ram_wr_addr;

    verlet_core_sequencer #(
        .WIDTH          (32),
        .NODES_PER_CORE (N),
        .ADDR_BASE      (BASE),
        .ADDR_STRIDE    (STRIDE),
        .STEP_W         (16),
        .WB_LATENCY     (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .num_steps   (num_steps),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .node_sel    (node_sel),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .step_cnt    (step_cnt),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Input plans, indexed by cycle.
    bit          p_rst   [TOTAL];
    bit          p_start [TOTAL];
    bit          p_stall [TOTAL];
    logic [15:0] p_ns    [TOTAL];

    // Expected outputs, indexed by cycle.
    bit          e_busy  [TOTAL];
    bit          e_done  [TOTAL];
    bit          e_fetch [TOTAL];
    bit          e_rden  [TOTAL];
    int          e_node  [TOTAL];
    logic [15:0] e_step  [TOTAL];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit chk_on   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic put(input int u, input bit b, input bit d, input bit f, input int node,
                       input bit rd, input logic [15:0] stp);
        if (u < TOTAL) begin
            e_busy[u]  = b;
            e_done[u]  = d;
            e_fetch[u] = f;
            e_node[u]  = node;
            e_rden[u]  = rd;
            e_step[u]  = stp;
        end
    endtask

    // Step to the next cycle; abort the run if reset was high in the previous one.
    task automatic adv(inout int u, output bit ab);
        u  = u + 1;
        ab = (u >= TOTAL) || p_rst[u-1];
    endtask

    task automatic build_model();
        int          t;
        int          u;
        bit          ab;
        bit          again;
        logic [15:0] cnt;
        logic [15:0] s_tot;
        t   = 0;
        cnt = '0;
        put(0, 0, 0, 0, 0, 0, cnt);
        while (t < TOTAL - 1) begin
            if (p_rst[t]) begin
                cnt = '0;
                t++;
                put(t, 0, 0, 0, 0, 0, cnt);
            end else if (!p_start[t]) begin
                t++;
                put(t, 0, 0, 0, 0, 0, cnt);
            end else begin
                s_tot = p_ns[t];
                cnt   = '0;
                u     = t;
                ab    = 1'b0;
                for (int s = 0; s < int'(s_tot) && !ab; s++) begin
                    for (int i = 0; i < N && !ab; i++) begin
                        again = 1'b1;
                        while (again && !ab) begin
                            adv(u, ab);
                            if (!ab) begin
                                put(u, 1, 0, 1, i, !p_stall[u], cnt);
                                again = p_stall[u];
                            end
                        end
                    end
                    if (!ab) begin
                        adv(u, ab);
                        if (!ab) begin
                            put(u, 1, 0, 0, 0, 0, cnt);
                            cnt = cnt + 16'd1;
                        end
                    end
                end
                if (s_tot != 0) begin
                    for (int k = 0; k < LX && !ab; k++) begin
                        adv(u, ab);
                        if (!ab) put(u, 1, 0, 0, 0, 0, cnt);
                    end
                end
                if (!ab) begin
                    adv(u, ab);
                    if (!ab) put(u, 0, 1, 0, 0, 0, cnt);
                end
                if (!ab) begin
                    adv(u, ab);
                    if (!ab) put(u, 0, 0, 0, 0, 0, cnt);
                end
                if (u >= TOTAL) begin
                    t = TOTAL;
                end else begin
                    if (ab) begin
                        cnt = '0;
                        put(u, 0, 0, 0, 0, 0, cnt);
                    end
                    t = u;
                end
            end
        end
    endtask

    // Single compare process: model schedule every cycle plus literal anchors.
    always @(negedge clk) begin : cmp
        logic [N-1:0] esel;
        logic [31:0]  eaddr;
        if (chk_on) begin
            esel  = e_fetch[cyc] ? (N'(1) << e_node[cyc]) : '0;
            eaddr = 32'(BASE) + 32'(e_node[cyc]) * 32'(STRIDE);
            check("busy", busy, e_busy[cyc]);
            check("done", done, e_done[cyc]);
            check("node_sel", node_sel, esel);
            check("ram_rd_en", ram_rd_en, e_rden[cyc]);
            check("step_cnt", step_cnt, e_step[cyc]);
            if (e_fetch[cyc]) check("ram_rd_addr", ram_rd_addr, eaddr);
`ifdef VERLET_SEQ_WRITEBACK_EN
            begin : wb
                int  src;
                bit  flushed;
                bit  ewr;
                src     = cyc - LAT;
                flushed = 1'b0;
                for (int k = (src < 0 ? 0 : src); k < cyc; k++) flushed |= p_rst[k];
                ewr = (src >= 0) && !flushed && e_rden[src];
                check("ram_wr_en", ram_wr_en, ewr);
                if (src >= 0 && !flushed && e_fetch[src]) begin
                    check("ram_wr_addr", ram_wr_addr,
                          32'(BASE) + 32'(e_node[src]) * 32'(STRIDE));
                end
            end
`else
            check("ram_wr_en_off", ram_wr_en, 0);
            check("ram_wr_addr_off", ram_wr_addr, 0);
`endif
            // Hand-computed anchors for the directed runs.
            if (cyc == 0)  check("lit_reset_busy", busy, 0);
            if (cyc == 3)  check("lit_a_addr_n0", ram_rd_addr, 1);
            if (cyc == 5)  check("lit_a_addr_n2", ram_rd_addr, 11);
            if (cyc == 7)  check("lit_a_addr_n4", ram_rd_addr, 21);
            if (cyc == 8)  check("lit_a_sync_sel", node_sel, 0);
            if (cyc == 9)  check("lit_a_addr_step2", ram_rd_addr, 1);
            if (cyc == 15 + LX) check("lit_a_done", done, 1);
            if (cyc == 16 + LX) check("lit_a_step_cnt", step_cnt, 2);
            if (cyc == 23) check("lit_b_hold_addr", ram_rd_addr, 11);
            if (cyc == 23) check("lit_b_stall_rden", ram_rd_en, 0);
            if (cyc == 24) check("lit_b_hold_addr2", ram_rd_addr, 11);
            if (cyc == 25) check("lit_b_resume_rden", ram_rd_en, 1);
            if (cyc == 25) check("lit_b_resume_addr", ram_rd_addr, 11);
            if (cyc == 29 + LX) check("lit_b_done", done, 1);
            if (cyc == 36) check("lit_c_done", done, 1);
            if (cyc == 36) check("lit_c_busy", busy, 0);
            if (cyc == 47 + LX) check("lit_d_done", done, 1);
            if (cyc == 48 + LX) check("lit_d_step_cnt", step_cnt, 1);
            if (cyc == 69) check("lit_e_reset_busy", busy, 0);
            if (cyc == 69) check("lit_e_reset_step", step_cnt, 0);
            if (cyc == 82 + LX) check("lit_e_restart_done", done, 1);
`ifdef VERLET_SEQ_WRITEBACK_EN
            if (cyc == 94)  check("lit_f_wr_en", ram_wr_en, 1);
            if (cyc == 94)  check("lit_f_wr_addr0", ram_wr_addr, 1);
            if (cyc == 98)  check("lit_f_wr_addr4", ram_wr_addr, 21);
            if (cyc == 99)  check("lit_f_drain_busy", busy, 1);
            if (cyc == 100) check("lit_f_done", done, 1);
`endif
        end
    end

    initial begin
        for (int c = 0; c < TOTAL; c++) begin
            p_rst[c]   = 1'b0;
            p_start[c] = 1'b0;
            p_stall[c] = 1'b0;
            p_ns[c]    = 16'($urandom_range(0, 3));
        end
        // Directed runs.
        p_start[2]  = 1'b1; p_ns[2]  = 16'd2;
        p_start[20] = 1'b1; p_ns[20] = 16'd1;
        p_stall[23] = 1'b1; p_stall[24] = 1'b1;
        p_start[35] = 1'b1; p_ns[35] = 16'd0;
        p_start[40] = 1'b1; p_ns[40] = 16'd1;
        p_start[44] = 1'b1; p_ns[44] = 16'd3;
        p_start[60] = 1'b1; p_ns[60] = 16'd3;
        p_rst[68]   = 1'b1;
        p_start[75] = 1'b1; p_ns[75] = 16'd1;
        p_start[90] = 1'b1; p_ns[90] = 16'd1;
        // Random traffic.
        for (int c = 110; c < TOTAL - 60; c++) begin
            p_start[c] = ($urandom_range(0, 5) == 0);
            p_stall[c] = ($urandom_range(0, 3) == 0);
            p_rst[c]   = ($urandom_range(0, 149) == 0);
        end
        build_model();

        reset     = 1'b1;
        start     = 1'b0;
        stall     = 1'b0;
        num_steps = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int c = 0; c < TOTAL; c++) begin
            cyc       = c;
            reset     = p_rst[c];
            start     = p_start[c];
            stall     = p_stall[c];
            num_steps = p_ns[c];
            chk_on    = 1'b1;
            @(posedge clk);
            #1;
        end
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
